// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path.
package alu_pkg;

  localparam int unsigned ALU_W     = 32;
  localparam int unsigned ALU_TAG_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } alu_flags_t;

  // Default-width entry; parameterised stages build an equivalent local struct.
  typedef struct packed {
    logic [ALU_W-1:0]     f;
    logic [ALU_TAG_W-1:0] tag;
    alu_flags_t           flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream and downstream result handshake bundle for alu_result_stage.
interface alu_result_stage_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_f;
  logic             in_cout;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_f;
  logic [TAG_W-1:0] out_tag;
  logic             out_z;
  logic             out_n;
  logic             out_c;

  // Environment view: produces results upstream, consumes them downstream.
  modport master (
    output in_valid, in_f, in_cout, in_tag, out_ready,
    input  in_ready, out_valid, out_f, out_tag, out_z, out_n, out_c
  );

  // Stage view.
  modport slave (
    input  in_valid, in_f, in_cout, in_tag, out_ready,
    output in_ready, out_valid, out_f, out_tag, out_z, out_n, out_c
  );
endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational Z/N/C flag derivation from an ALU result and its carry-out.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned N = ALU_W
) (
  input  logic [N-1:0] in_f,
  input  logic         in_cout,
  output alu_flags_t   flags
);
  always_comb begin
    flags   = '0;
    flags.z = ~|in_f;
    flags.n = in_f[N-1];
    flags.c = in_cout;
  end
endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer with stored flags and a
// saturating delivered-result counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned N     = ALU_W,
  parameter int unsigned TAG_W = ALU_TAG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_result_stage_if.slave  bus,
  output logic [CNT_W-1:0]   res_count
);
  typedef struct packed {
    logic [N-1:0]     f;
    logic [TAG_W-1:0] tag;
    alu_flags_t       flags;
  } entry_t;

  skid_state_e      state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_entry;
  alu_flags_t       in_flags;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop;

  alu_flag_gen #(.N(N)) u_flag_gen (
    .in_f    (bus.in_f),
    .in_cout (bus.in_cout),
    .flags   (in_flags)
  );

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    new_entry       = '0;
    new_entry.f     = bus.in_f;
    new_entry.tag   = bus.in_tag;
    new_entry.flags = in_flags;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = new_entry;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = FULL;
            skid_d  = new_entry;
          end else if (push && pop) begin
            main_d  = new_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered ready breaks any out_ready -> in_ready combinational path.
      in_ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pop && !flush && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_f     = main_q.f;
  assign bus.out_tag   = main_q.tag;
  assign bus.out_z     = main_q.flags.z;
  assign bus.out_n     = main_q.flags.n;
  assign bus.out_c     = main_q.flags.c;
  assign res_count     = cnt_q;
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the combinational ALU function units (Not32Bit and its siblings).
- Captures a unit's result F with its carry-out and an issue tag, and derives the Z, N and C flags.
- Presents the result to the writeback consumer over a valid/ready handshake, through a 2-entry skid buffer.
- Gives full throughput with no combinational path from out_ready to in_ready; also keeps a saturating count of delivered results.

Parameters:
- N, 32, data width of F (matches ALU width).
- TAG_W, 4, width of the issue tag carried alongside each result.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; registered.
- in_f  input  N  ALU result F.
- in_cout  input  1  carry-out from the arithmetic unit; 0 for logic units such as NOT.
- in_tag  input  TAG_W  issue tag.
- flush  input  1  synchronous discard of all buffered entries.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_f  output  N  buffered result.
- out_tag  output  TAG_W  buffered tag.
- out_z  output  1  zero flag, out_f == 0.
- out_n  output  1  negative flag, out_f[N-1].
- out_c  output  1  carry flag, stored in_cout.
- res_count  output  CNT_W  number of out handshakes since reset; saturating.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. While rst_n=0 all of the following hold:
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_f=0, out_tag=0, out_z=0, out_n=0, out_c=0, res_count=0.
  - Reset asserted mid-transfer discards all entries immediately.
- Handshakes:
  - Push occurs when in_valid & in_ready at a rising edge.
  - Pop occurs when out_valid & out_ready at a rising edge.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Flags: computed from in_f/in_cout at push time and stored with the entry, never recomputed from the output register.
- Storage: main register (drives the out_* ports) and skid register.
- State machine, with push/pop as above:
  - EMPTY: push -> ONE (entry to main).
  - ONE: push & !pop -> FULL (entry to skid). push & pop -> ONE (new entry to main). pop & !push -> EMPTY.
  - FULL: in_ready=0, so no push. pop -> ONE (skid moves to main).
- Outputs per state: out_valid = (state != EMPTY). in_ready = (state != FULL) and is a flop updated with the next state.
- Latency: 1 cycle from push to out_valid when EMPTY. Sustained 1 result/cycle while out_ready=1. Strict FIFO order.
- Flush:
  - Next state is EMPTY and out_valid=0 the following cycle.
  - A push or pop in the same cycle is ignored; the pop does not count.
  - Stored data need not be cleared.
  - flush has priority over push/pop but not over rst_n.
- res_count: increments by 1 on each pop. Holds at 2^CNT_W-1 (no wrap). Not cleared by flush.
- Widths: no truncation. out_z is the reduction NOR over all N bits.

Decomposition:
- Shared package alu_pkg:
  - Constant ALU_W=32.
  - Typedef skid_state_e {EMPTY, ONE, FULL} as a 2-bit enum.
  - Packed struct alu_flags_t {z, n, c}.
  - Packed struct alu_entry_t {f, tag, flags}.
- Sub-module alu_flag_gen: combinational in_f/in_cout -> alu_flags_t. Reusable by other ALU stages.

Test Plan:
- Reset values: hold rst_n=0 with random inputs -> out_valid=0, in_ready=1, res_count=0, all data/flag outputs 0. Release -> same until first push.
- NOT of 0, then ADD: push in_f=0xFFFFFFFF, tag=3, cout=0, out_ready=1 -> next cycle out_valid=1, out_f=0xFFFFFFFF, out_n=1, out_z=0, out_c=0, tag=3. Then push in_f=0, cout=1 -> out_z=1, out_n=0, out_c=1. res_count=2.
- Backpressure: out_ready=0, offer tags 1,2,3 back-to-back -> in_ready=0 after the 2nd push, tag 3 held upstream. Raise out_ready -> tags pop in order 1,2,3 with no gaps; in_ready returns 1 one cycle after the first pop.
- Simultaneous push/pop in ONE: steady stream of 8 pushes with out_ready=1 -> state stays ONE, out_valid continuous, 8 results in order, res_count=8.
- Flush: FULL with tags 5,6 while out_ready=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, res_count unchanged, tags 5/6 and the offered entry never appear.
- Saturation and mid-op reset: CNT_W=4, 20 pops -> res_count=15. Assert rst_n=0 asynchronously between edges while FULL -> outputs clear immediately; after release the stage accepts new data normally.
